// File: rtl/rca_sched_pkg.sv
// Shared definitions for the nibble-serial add scheduler: FSM encoding,
// datapath nibble width and requester id constants.
package rca_sched_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/Ripple_carry_adder.sv
// 4-bit ripple-carry adder: the only combinational add in the scheduler.
module Ripple_carry_adder
  import rca_sched_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] carry;

  // Full-adder chain, carry propagating from bit 0 upward
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[NIBBLE_W];

endmodule

// File: rtl/rca_add_scheduler.sv
// Two-requester round-robin add scheduler; each W-bit add is run LSB nibble
// first through one shared 4-bit ripple-carry adder.
module rca_add_scheduler
  import rca_sched_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   req0_a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   req0_b,
  input  logic                          req0_cin,
  input  logic                          req1_valid,
  output logic                          req1_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   req1_a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   req1_b,
  input  logic                          req1_cin,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   rsp_sum,
  output logic                          rsp_cout,
  output logic                          rsp_id,
  output logic                          busy
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e                state_q, state_d;
  logic [W-1:0]          a_sh_q, b_sh_q, res_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  carry_q, last_grant_q, rsp_valid_q, rsp_cout_q, rsp_id_q;
  logic                  grant_c, accept_c, last_nib_c;
  logic [NIBBLE_W-1:0]   nib_sum;
  logic                  nib_cout;

  Ripple_carry_adder u_rca (
    .a    (a_sh_q[NIBBLE_W-1:0]),
    .b    (b_sh_q[NIBBLE_W-1:0]),
    .c    (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Round-robin: on a tie, the requester not granted last time wins
  always_comb begin
    grant_c = REQ0;
    if (req0_valid && req1_valid) grant_c = ~last_grant_q;
    else if (req1_valid)          grant_c = REQ1;
  end

  assign accept_c   = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
  assign last_nib_c = (cnt_q == CNT_W'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_c)   state_d = ADD;
      ADD:     if (last_nib_c) state_d = DONE;
      DONE:    if (rsp_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = (state_q != IDLE);
    if (accept_c) begin
      req0_ready = (grant_c == REQ0);
      req1_ready = (grant_c == REQ1);
    end
  end

  // Operand shifters, serial carry and result assembly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      carry_q      <= 1'b0;
      last_grant_q <= REQ1;
      rsp_valid_q  <= 1'b0;
      rsp_cout_q   <= 1'b0;
      rsp_id_q     <= REQ0;
    end else begin
      rsp_valid_q <= (state_d == DONE);
      if (accept_c) begin
        a_sh_q       <= (grant_c == REQ1) ? req1_a : req0_a;
        b_sh_q       <= (grant_c == REQ1) ? req1_b : req0_b;
        carry_q      <= (grant_c == REQ1) ? req1_cin : req0_cin;
        cnt_q        <= '0;
        rsp_id_q     <= grant_c;
        last_grant_q <= grant_c;
      end else if (state_q == ADD) begin
        a_sh_q  <= a_sh_q >> NIBBLE_W;
        b_sh_q  <= b_sh_q >> NIBBLE_W;
        carry_q <= nib_cout;
        cnt_q   <= cnt_q + CNT_W'(1);
        res_q   <= (res_q >> NIBBLE_W) | (W'(nib_sum) << (W - NIBBLE_W));
        if (last_nib_c) rsp_cout_q <= nib_cout;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = res_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_rca_add_scheduler.sv
// Randomized self-checking bench for rca_add_scheduler against an arithmetic
// and round-robin reference model (NIBBLES = 4 main instance, NIBBLES = 1 aux).
module tb_rca_add_scheduler;

  localparam int unsigned N0 = 4;
  localparam int unsigned W0 = 4 * N0;
  localparam int unsigned N1 = 1;
  localparam int unsigned W1 = 4 * N1;

  logic clk, rst_n;

  logic          req0_valid, req0_ready, req0_cin;
  logic [W0-1:0] req0_a, req0_b;
  logic          req1_valid, req1_ready, req1_cin;
  logic [W0-1:0] req1_a, req1_b;
  logic          rsp_valid, rsp_ready, rsp_cout, rsp_id, busy;
  logic [W0-1:0] rsp_sum;

  logic          s_req0_valid, s_req0_ready, s_req0_cin;
  logic [W1-1:0] s_req0_a, s_req0_b;
  logic          s_req1_valid, s_req1_ready, s_req1_cin;
  logic [W1-1:0] s_req1_a, s_req1_b;
  logic          s_rsp_valid, s_rsp_ready, s_rsp_cout, s_rsp_id, s_busy;
  logic [W1-1:0] s_rsp_sum;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: pending requests and last granted requester
  bit            pv[2];
  logic [W0-1:0] pa[2];
  logic [W0-1:0] pb[2];
  logic          pc[2];
  int            last_g;

  rca_add_scheduler #(.NIBBLES(N0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_id(rsp_id), .busy(busy)
  );

  rca_add_scheduler #(.NIBBLES(N1)) dut_n1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_a(s_req0_a), .req0_b(s_req0_b), .req0_cin(s_req0_cin),
    .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_a(s_req1_a), .req1_b(s_req1_b), .req1_cin(s_req1_cin),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_sum(s_rsp_sum), .rsp_cout(s_rsp_cout),
    .rsp_id(s_rsp_id), .busy(s_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [W0-1:0] a, input logic [W0-1:0] b, input logic c);
    pv[id] = 1'b1; pa[id] = a; pb[id] = b; pc[id] = c;
    if (id == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = c;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = c;
    end
  endtask

  // Called at a negedge with the scheduler idle and at least one request pending.
  task automatic serve_one(input int hold);
    int            g;
    logic [W0:0]   full;
    if (pv[0] && pv[1]) g = (last_g == 0) ? 1 : 0;
    else if (pv[1])     g = 1;
    else                g = 0;
    full = {1'b0, pa[g]} + {1'b0, pb[g]} + (W0+1)'(pc[g]);
    rsp_ready = (hold == 0);
    #1;
    chk("grant_ready0", 32'(req0_ready), 32'(g == 0));
    chk("grant_ready1", 32'(req1_ready), 32'(g == 1));
    chk("idle_busy", 32'(busy), 32'(0));
    @(posedge clk); @(negedge clk);
    last_g = g;
    pv[g]  = 1'b0;
    if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    chk("add_busy", 32'(busy), 32'(1));
    chk("add_ready", 32'({req1_ready, req0_ready}), 32'(0));
    for (int i = 1; i <= int'(N0); i++) begin
      @(posedge clk); @(negedge clk);
      chk("latency_valid", 32'(rsp_valid), 32'(i == int'(N0)));
    end
    chk("rsp_sum", 32'(rsp_sum), 32'(full[W0-1:0]));
    chk("rsp_cout", 32'(rsp_cout), 32'(full[W0]));
    chk("rsp_id", 32'(rsp_id), 32'(g));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'(1));
      chk("hold_sum", 32'({rsp_id, rsp_cout, rsp_sum}), 32'({g[0], full}));
      chk("hold_busy", 32'(busy), 32'(1));
      chk("hold_ready", 32'({req1_ready, req0_ready}), 32'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_hs_valid", 32'(rsp_valid), 32'(0));
    chk("post_hs_busy", 32'(busy), 32'(0));
    rsp_ready = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 4 && (pv[0] || pv[1]); k++) serve_one(0);
  endtask

  initial begin
    logic [W1:0]   sfull;
    logic [W1-1:0] sa, sb;
    logic          sc;
    int            sid;

    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    s_req0_valid = 1'b0; s_req0_a = '0; s_req0_b = '0; s_req0_cin = 1'b0;
    s_req1_valid = 1'b0; s_req1_a = '0; s_req1_b = '0; s_req1_cin = 1'b0;
    s_rsp_ready = 1'b0;
    pv[0] = 1'b0; pv[1] = 1'b0; last_g = 1;

    // Reset values, with ready gated while rst_n is low
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 32'(0));
    chk("rst_sum", 32'(rsp_sum), 32'(0));
    chk("rst_cout_id", 32'({rsp_cout, rsp_id}), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ready", 32'({req1_ready, req0_ready}), 32'(0));
    chk("rst_n1_valid", 32'(s_rsp_valid), 32'(0));
    req0_valid = 1'b0;
    rst_n = 1'b1;

    // Single request and full ripple
    set_req(0, 16'h1234, 16'h4321, 1'b0);
    serve_one(0);
    set_req(1, 16'hFFFF, 16'h0000, 1'b1);
    serve_one(1);

    // Tie right after reset, then alternation
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; last_g = 1;
    set_req(0, 16'h0007, 16'h0006, 1'b0);
    set_req(1, 16'h8000, 16'h8000, 1'b0);
    serve_one(0);
    serve_one(0);
    set_req(0, 16'h0F0F, 16'h00F1, 1'b1);
    set_req(1, 16'h7FFF, 16'h0001, 1'b0);
    serve_one(0);
    drain();

    // Backpressure in DONE with the other requester waiting
    set_req(0, 16'hA5A5, 16'h5A5B, 1'b0);
    set_req(1, 16'h1111, 16'h2222, 1'b1);
    serve_one(10);
    drain();

    // Reset on the second ADD cycle discards the add
    set_req(0, 16'hABCD, 16'h1111, 1'b1);
    #1;
    chk("rstmid_accept", 32'(req0_ready), 32'(1));
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0; pv[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rstmid_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    set_req(0, 16'h00FF, 16'h0001, 1'b0);
    #1;
    chk("rstmid_ready_gated", 32'(req0_ready), 32'(0));
    @(posedge clk); @(negedge clk);
    chk("rstmid_valid", 32'(rsp_valid), 32'(0));
    chk("rstmid_sum", 32'(rsp_sum), 32'(0));
    chk("rstmid_cout_id", 32'({rsp_cout, rsp_id}), 32'(0));
    chk("rstmid_busy0", 32'(busy), 32'(0));
    rst_n = 1'b1; last_g = 1;
    serve_one(0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int id = 0; id < 2; id++) begin
        if (!pv[id] && ($urandom_range(0, 2) != 0)) begin
          logic [W0-1:0] ra, rb;
          ra = 16'($urandom);
          rb = 16'($urandom);
          if ($urandom_range(0, 5) == 0) ra = 16'hFFFF;
          set_req(id, ra, rb, 1'($urandom_range(0, 1)));
        end
      end
      if (!pv[0] && !pv[1]) set_req(int'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'b1);
      serve_one(int'($urandom_range(0, 3)));
    end
    drain();

    // NIBBLES = 1 instance: single-cycle add latency
    for (int it = 0; it < 7; it++) begin
      if (it == 0) begin
        sa = 4'h9; sb = 4'h8; sc = 1'b1; sid = 0;
      end else begin
        sa = 4'($urandom); sb = 4'($urandom); sc = 1'($urandom_range(0, 1)); sid = it % 2;
      end
      sfull = {1'b0, sa} + {1'b0, sb} + (W1+1)'(sc);
      if (sid == 0) begin
        s_req0_valid = 1'b1; s_req0_a = sa; s_req0_b = sb; s_req0_cin = sc;
      end else begin
        s_req1_valid = 1'b1; s_req1_a = sa; s_req1_b = sb; s_req1_cin = sc;
      end
      #1;
      chk("n1_ready", 32'({s_req1_ready, s_req0_ready}), (sid == 0) ? 32'(1) : 32'(2));
      @(posedge clk); @(negedge clk);
      s_req0_valid = 1'b0; s_req1_valid = 1'b0;
      chk("n1_add_valid", 32'(s_rsp_valid), 32'(0));
      chk("n1_add_busy", 32'(s_busy), 32'(1));
      @(posedge clk); @(negedge clk);
      chk("n1_valid", 32'(s_rsp_valid), 32'(1));
      chk("n1_sum", 32'(s_rsp_sum), 32'(sfull[W1-1:0]));
      chk("n1_cout_id", 32'({s_rsp_cout, s_rsp_id}), 32'({sfull[W1], sid[0]}));
      s_rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("n1_post_valid", 32'(s_rsp_valid), 32'(0));
      s_rsp_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
